prv_trap_sequencer: RTL and testbench
=====================================

# prv_trap_sequencer

Machine-mode trap and return sequencer on the `prv` side of `csr_prv_if`.
- Accepts one synchronous exception, pending interrupt or MRET at a time.
- Commits the required CSR updates (mepc, mcause, mbadaddr, mstatus) over fixed cycles through the `*_rup`/`*_next` strobes.
- Then presents a PC redirect to the fetch stage and holds it until acknowledged.
- Sits between the pipeline hazard/exception logic and the CSR register file.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0200: value driven on `redirect_pc` while not redirecting.

Ports:
- `CLK`  in  1  system clock; all state changes on rising edge.
- `RST`  in  1  reset, synchronous, active-high.
- `ex_valid`  in  1  pipeline reports an exception; held until `trap_ack`.
- `ex_cause`  in  4  exception code (0–11).
- `ex_epc`  in  32  PC of the faulting instruction.
- `ex_badaddr`  in  32  faulting address (0 if not applicable).
- `mret_valid`  in  1  MRET retiring; held until `trap_ack`.
- `int_pc`  in  32  PC to save as mepc for an interrupt (next unretired instruction).
- `mtvec`  in  32  trap vector base from the CSR file.
- `trap_ack`  out  1  one-cycle pulse: request accepted.
- `busy`  out  1  sequencer not IDLE; pipeline must stall.
- `redirect_valid`  out  1  `redirect_pc` is valid.
- `redirect_pc`  out  32  new fetch PC.
- `redirect_ack`  in  1  fetch has taken the redirect.
- `prv_if`  modport  —  `csr_prv_if.prv`.

## Operation
States: IDLE, SAVE, STATUS, RESTORE, REDIRECT.

Arbitration (IDLE only, fixed priority):
1. `ex_valid`.
2. `mret_valid`.
3. Interrupt.

- The interrupt path is eligible when `mstatus.mie`=1 and (`mip & mie`) is nonzero.
- Interrupt priority, highest first: MEI (11), MSI (3), MTI (7).
- On accept, `trap_ack` pulses and the request fields are captured:
  - cause is latched as a 32-bit mcause: bit31 = interrupt, low bits = code.
  - the saved epc is latched: `ex_epc` for exceptions, `int_pc` for interrupts.
  - badaddr is latched: `ex_badaddr` for exceptions, 0 for interrupts.

Per-state behaviour:
- Trap path: IDLE→SAVE→STATUS→REDIRECT.
- SAVE:
  - `mepc_rup`=`mcause_rup`=`mbadaddr_rup`=1 for exactly one cycle.
  - `*_next` carry the latched values.
- STATUS:
  - `mstatus_rup`=1 for one cycle.
  - `mstatus_next` = current mstatus with mpie←mie, mie←0, mpp←2'b11.
- MRET path: IDLE→RESTORE→REDIRECT.
- RESTORE:
  - `mstatus_rup`=1 for one cycle.
  - `mstatus_next` = mstatus with mie←mpie, mpie←1, mpp←2'b11.
- REDIRECT:
  - `redirect_valid`=1.
  - `redirect_pc` = {mtvec[31:2],2'b00} for a trap, or the current `prv_if.mepc` for MRET.
  - Held stable until `redirect_ack`, then →IDLE.

Other behaviour:
- `mip_rup` is tied 0; mip is owned by the CSR file.
- `mip_next` is driven equal to `mip`.
- All `*_next` outputs are don't-care when their `*_rup`=0; they are driven to the latched or current value, never X.

## Timing
- Reset values: IDLE, `trap_ack`=0, `busy`=0, `redirect_valid`=0, `redirect_pc`=`RESET_PC`, all `*_rup`=0, latched fields 0.
- Trap latency: request at cycle 0 (IDLE) → SAVE at cycle 1 → STATUS at cycle 2 → `redirect_valid` from cycle 3.
- MRET latency: `redirect_valid` from cycle 2.
- `busy` is high from cycle 1 until the cycle after `redirect_ack`. It is combinationally high in cycle 0 when a request is present.
- `redirect_ack` in the same cycle `redirect_valid` first rises is legal; IDLE follows next cycle.
- No new request is accepted in the ack cycle; the earliest next `trap_ack` is the first IDLE cycle.
- Requests present outside IDLE are ignored and not queued; requesters hold.
- `ex_valid` and `mret_valid` together: exception taken; MRET stays pending and is not acked.
- Interrupt that becomes pending while busy: evaluated in the next IDLE cycle. mstatus.mie is 0 after a trap, so none is taken until MRET.
- `RST` in any state: next cycle is IDLE with reset values.
  - CSR writes already strobed remain committed.
  - Remaining writes of the aborted sequence are not issued.

## Structure
- Add `prv_state_t` (5-state enum) and the interrupt code constants (MSI=3, MTI=7, MEI=11) to `machine_mode_types_pkg`.
- Sub-module `prv_int_prio`: combinational encoder of (`mip & mie`, `mstatus.mie`) → {pending, 4-bit code}.

## Test plan
- Reset, then idle 10 cycles → every `*_rup`=0, `busy`=0, `redirect_pc`=`RESET_PC`.
- `ex_valid`, cause=2, epc=0x100, badaddr=0x0, mtvec=0x1C1, mstatus.mie=1:
  - cycle 1 mepc_next=0x100, mcause_next=0x2.
  - cycle 2 mstatus_next mie=0, mpie=1.
  - cycle 3 `redirect_pc`=0x1C0.
- `mret_valid`, mepc=0x104, mpie=1 → cycle 1 mstatus_next mie=1; cycle 2 `redirect_pc`=0x104.
- mie=mip=0x888, mstatus.mie=1, int_pc=0x40 → mcause_next=0x8000_000B, mepc_next=0x40.
- `ex_valid` and `mret_valid` together → exception sequence. Hold `redirect_ack` low 5 cycles → PC stable. After ack, MRET accepted next IDLE.
- Assert `RST` in STATUS → no `mstatus_rup`; IDLE next cycle; `redirect_valid` never asserted.

Source files
------------

// File: rtl/prv_trap_sequencer_pkg.sv
// rtl/prv_trap_sequencer_pkg.sv - machine-mode types shared by the trap sequencer
// Purpose: sequencer state encoding, interrupt codes, mstatus field positions
//          and the two mstatus rewrite rules (trap entry, MRET).
`timescale 1ns/1ps
package machine_mode_types_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SAVE,
      ST_STATUS,
      ST_RESTORE,
      ST_REDIRECT
   } prv_state_t;

   localparam logic [3:0] INT_MSI = 4'd3;
   localparam logic [3:0] INT_MTI = 4'd7;
   localparam logic [3:0] INT_MEI = 4'd11;

   // Only the three machine-level sources can raise an interrupt.
   localparam logic [31:0] INT_SRC_MASK = 32'h0000_0888;

   localparam int MST_MIE    = 3;
   localparam int MST_MPIE   = 7;
   localparam int MST_MPP_LO = 11;
   localparam int MST_MPP_HI = 12;

   // Trap entry: stack the interrupt enable and force machine mode.
   function automatic logic [31:0] trap_mstatus(input logic [31:0] ms);
      logic [31:0] r;
      r = ms;
      r[MST_MPIE] = ms[MST_MIE];
      r[MST_MIE] = 1'b0;
      r[MST_MPP_HI:MST_MPP_LO] = 2'b11;
      return r;
   endfunction

   // MRET: pop the interrupt enable, re-arm mpie.
   function automatic logic [31:0] mret_mstatus(input logic [31:0] ms);
      logic [31:0] r;
      r = ms;
      r[MST_MIE] = ms[MST_MPIE];
      r[MST_MPIE] = 1'b1;
      r[MST_MPP_HI:MST_MPP_LO] = 2'b11;
      return r;
   endfunction

endpackage

// File: rtl/prv_trap_sequencer_if.sv
// rtl/prv_trap_sequencer_if.sv - CSR file <-> trap sequencer bus
// Purpose: carries current CSR values to the sequencer and update strobes back.
// Ports (modport prv): in mepc/mstatus/mip/mie; out *_rup/*_next for
//          mepc, mcause, mbadaddr, mstatus, mip. Modport csr is the mirror.
`timescale 1ns/1ps
interface csr_prv_if;
   logic [31:0] mepc;
   logic [31:0] mstatus;
   logic [31:0] mip;
   logic [31:0] mie;

   logic        mepc_rup;
   logic [31:0] mepc_next;
   logic        mcause_rup;
   logic [31:0] mcause_next;
   logic        mbadaddr_rup;
   logic [31:0] mbadaddr_next;
   logic        mstatus_rup;
   logic [31:0] mstatus_next;
   logic        mip_rup;
   logic [31:0] mip_next;

   modport prv (
      input  mepc, mstatus, mip, mie,
      output mepc_rup, mepc_next, mcause_rup, mcause_next,
             mbadaddr_rup, mbadaddr_next, mstatus_rup, mstatus_next,
             mip_rup, mip_next
   );

   modport csr (
      output mepc, mstatus, mip, mie,
      input  mepc_rup, mepc_next, mcause_rup, mcause_next,
             mbadaddr_rup, mbadaddr_next, mstatus_rup, mstatus_next,
             mip_rup, mip_next
   );
endinterface

// File: rtl/prv_trap_sequencer_int_prio.sv
// rtl/prv_trap_sequencer_int_prio.sv - machine interrupt priority encoder
// Purpose: picks the highest-priority enabled pending interrupt (MEI > MSI > MTI).
// Ports: pend_en_i (mip & mie), mstatus_mie_i (global enable),
//        int_pending_o (interrupt eligible), int_code_o (4-bit cause code).
`timescale 1ns/1ps
module prv_int_prio
   import machine_mode_types_pkg::*;
(
   input  logic [31:0] pend_en_i,
   input  logic        mstatus_mie_i,
   output logic        int_pending_o,
   output logic [3:0]  int_code_o
);

   logic [31:0] src;

   always_comb begin
      src = pend_en_i & INT_SRC_MASK;
      int_pending_o = mstatus_mie_i && (src != 32'd0);
      int_code_o = 4'd0;
      if (src[INT_MEI]) begin
         int_code_o = INT_MEI;
      end else if (src[INT_MSI]) begin
         int_code_o = INT_MSI;
      end else if (src[INT_MTI]) begin
         int_code_o = INT_MTI;
      end
   end

endmodule

// File: rtl/prv_trap_sequencer.sv
// rtl/prv_trap_sequencer.sv - machine-mode trap / MRET sequencer
// Purpose: accepts one exception, MRET or interrupt at a time, commits the CSR
//          updates over fixed cycles, then holds a PC redirect until acknowledged.
// Ports: CLK/RST (sync active-high); ex_* exception request; mret_valid;
//        int_pc (mepc for interrupts); mtvec; trap_ack pulse; busy stall;
//        redirect_valid/redirect_pc/redirect_ack fetch handshake; prv_if CSR bus.
`timescale 1ns/1ps
module prv_trap_sequencer
   import machine_mode_types_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0200
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        ex_valid,
   input  logic [3:0]  ex_cause,
   input  logic [31:0] ex_epc,
   input  logic [31:0] ex_badaddr,
   input  logic        mret_valid,
   input  logic [31:0] int_pc,
   input  logic [31:0] mtvec,
   output logic        trap_ack,
   output logic        busy,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   input  logic        redirect_ack,
   csr_prv_if.prv      prv_if
);

   prv_state_t  state_q, state_d;
   logic [31:0] cause_q, cause_d;
   logic [31:0] epc_q, epc_d;
   logic [31:0] badaddr_q, badaddr_d;
   logic        mret_q, mret_d;

   logic        int_pending;
   logic [3:0]  int_code;
   logic        accept;
   logic [31:0] target_pc;

   prv_int_prio u_int_prio (
      .pend_en_i     (prv_if.mip & prv_if.mie),
      .mstatus_mie_i (prv_if.mstatus[MST_MIE]),
      .int_pending_o (int_pending),
      .int_code_o    (int_code)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= ST_IDLE;
         cause_q   <= 32'd0;
         epc_q     <= 32'd0;
         badaddr_q <= 32'd0;
         mret_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cause_q   <= cause_d;
         epc_q     <= epc_d;
         badaddr_q <= badaddr_d;
         mret_q    <= mret_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cause_d   = cause_q;
      epc_d     = epc_q;
      badaddr_d = badaddr_q;
      mret_d    = mret_q;
      accept    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (ex_valid) begin
               accept    = 1'b1;
               state_d   = ST_SAVE;
               cause_d   = {28'd0, ex_cause};
               epc_d     = ex_epc;
               badaddr_d = ex_badaddr;
               mret_d    = 1'b0;
            end else if (mret_valid) begin
               // Latched trap fields are not touched by MRET.
               accept  = 1'b1;
               state_d = ST_RESTORE;
               mret_d  = 1'b1;
            end else if (int_pending) begin
               accept    = 1'b1;
               state_d   = ST_SAVE;
               cause_d   = {1'b1, 27'd0, int_code};
               epc_d     = int_pc;
               badaddr_d = 32'd0;
               mret_d    = 1'b0;
            end
         end
         ST_SAVE:     state_d = ST_STATUS;
         ST_STATUS:   state_d = ST_REDIRECT;
         ST_RESTORE:  state_d = ST_REDIRECT;
         ST_REDIRECT: begin
            if (redirect_ack) begin
               state_d = ST_IDLE;
            end
         end
         default:     state_d = ST_IDLE;
      endcase
   end

   // Strobes are masked during RST so an aborted sequence issues no further
   // CSR writes in the reset cycle itself.
   assign trap_ack = accept & ~RST;
   assign busy     = ~RST & ((state_q != ST_IDLE) | ex_valid | mret_valid | int_pending);

   // Vector mode bits of mtvec are ignored: all traps go to the base.
   assign target_pc      = mret_q ? prv_if.mepc : (mtvec & 32'hFFFF_FFFC);
   assign redirect_valid = ~RST & (state_q == ST_REDIRECT);
   assign redirect_pc    = redirect_valid ? target_pc : RESET_PC;

   assign prv_if.mepc_rup      = ~RST & (state_q == ST_SAVE);
   assign prv_if.mcause_rup    = ~RST & (state_q == ST_SAVE);
   assign prv_if.mbadaddr_rup  = ~RST & (state_q == ST_SAVE);
   assign prv_if.mepc_next     = epc_q;
   assign prv_if.mcause_next   = cause_q;
   assign prv_if.mbadaddr_next = badaddr_q;

   assign prv_if.mstatus_rup = ~RST & ((state_q == ST_STATUS) | (state_q == ST_RESTORE));

   always_comb begin
      prv_if.mstatus_next = prv_if.mstatus;
      if (state_q == ST_STATUS) begin
         prv_if.mstatus_next = trap_mstatus(prv_if.mstatus);
      end else if (state_q == ST_RESTORE) begin
         prv_if.mstatus_next = mret_mstatus(prv_if.mstatus);
      end
   end

   assign prv_if.mip_rup  = 1'b0;
   assign prv_if.mip_next = prv_if.mip;

endmodule

// File: tb/tb_prv_trap_sequencer.sv
// tb/tb_prv_trap_sequencer.sv - self-checking bench for prv_trap_sequencer
`timescale 1ns/1ps
module tb_prv_trap_sequencer;

   localparam logic [31:0] RESET_PC = 32'h0000_0200;

   logic        CLK;
   logic        RST;
   logic        ex_valid;
   logic [3:0]  ex_cause;
   logic [31:0] ex_epc;
   logic [31:0] ex_badaddr;
   logic        mret_valid;
   logic [31:0] int_pc;
   logic [31:0] mtvec;
   logic        trap_ack;
   logic        busy;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        redirect_ack;

   int checks = 0;
   int errors = 0;

   csr_prv_if csr_bus ();

   prv_trap_sequencer #(.RESET_PC(RESET_PC)) dut (
      .CLK            (CLK),
      .RST            (RST),
      .ex_valid       (ex_valid),
      .ex_cause       (ex_cause),
      .ex_epc         (ex_epc),
      .ex_badaddr     (ex_badaddr),
      .mret_valid     (mret_valid),
      .int_pc         (int_pc),
      .mtvec          (mtvec),
      .trap_ack       (trap_ack),
      .busy           (busy),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .redirect_ack   (redirect_ack),
      .prv_if         (csr_bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(posedge CLK);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idle_chk(input string tag);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_rv"}, 32'(redirect_valid), 32'd0);
      chk({tag, "_rpc"}, redirect_pc, RESET_PC);
      chk({tag, "_rups"}, 32'({csr_bus.mepc_rup, csr_bus.mcause_rup, csr_bus.mbadaddr_rup,
                               csr_bus.mstatus_rup, csr_bus.mip_rup}), 32'd0);
      chk({tag, "_mipn"}, csr_bus.mip_next, csr_bus.mip);
   endtask

   // Reference: decides which request wins and what every cycle must show,
   // then plays the CSR file by committing the expected values.
   task automatic do_req(input bit ev, input logic [3:0] ec, input logic [31:0] eepc,
                         input logic [31:0] ebad, input bit mv, input logic [31:0] ipc,
                         input logic [31:0] ip, input logic [31:0] ie, input logic [31:0] mst,
                         input logic [31:0] mtv, input int hold);
      int kind; // 0 none, 1 exception, 2 mret, 3 interrupt
      logic [31:0] cause, epc, bad, new_ms, target, pend;
      ex_valid = ev; ex_cause = ec; ex_epc = eepc; ex_badaddr = ebad;
      mret_valid = mv; int_pc = ipc; mtvec = mtv; redirect_ack = 1'b0;
      csr_bus.mip = ip; csr_bus.mie = ie; csr_bus.mstatus = mst;
      pend = ip & ie & 32'h888;
      cause = 0; epc = 0; bad = 0;
      if (ev) begin
         kind = 1; cause = 32'(ec); epc = eepc; bad = ebad;
      end else if (mv) begin
         kind = 2;
      end else if (mst[3] && pend != 0) begin
         kind = 3; epc = ipc; bad = 0;
         cause = 32'h8000_0000 + (pend[11] ? 32'd11 : (pend[3] ? 32'd3 : 32'd7));
      end else begin
         kind = 0;
      end
      settle();
      chk("c0_ack", 32'(trap_ack), 32'(kind != 0));
      chk("c0_busy", 32'(busy), 32'(kind != 0));
      chk("c0_rv", 32'(redirect_valid), 32'd0);
      if (kind == 0) return;
      nxt();
      if (kind == 1) ex_valid = 1'b0;
      if (kind == 2) mret_valid = 1'b0;
      settle();
      chk("c1_ack", 32'(trap_ack), 32'd0);
      chk("c1_busy", 32'(busy), 32'd1);
      if (kind != 2) begin
         chk("save_rups", 32'({csr_bus.mepc_rup, csr_bus.mcause_rup, csr_bus.mbadaddr_rup,
                               csr_bus.mstatus_rup}), 32'b1110);
         chk("save_mepc", csr_bus.mepc_next, epc);
         chk("save_mcause", csr_bus.mcause_next, cause);
         chk("save_mbad", csr_bus.mbadaddr_next, bad);
         nxt();
         csr_bus.mepc = epc;
         settle();
         new_ms = (mst & ~32'h1888) | (mst[3] ? 32'h80 : 32'h0) | 32'h1800;
         target = mtv & ~32'd3;
      end else begin
         new_ms = (mst & ~32'h1888) | (mst[7] ? 32'h8 : 32'h0) | 32'h1880;
         target = csr_bus.mepc;
      end
      chk("st_rup", 32'({csr_bus.mstatus_rup, csr_bus.mepc_rup}), 32'b10);
      chk("st_next", csr_bus.mstatus_next, new_ms);
      chk("st_rv", 32'(redirect_valid), 32'd0);
      nxt();
      csr_bus.mstatus = new_ms;
      for (int i = 0; i <= hold; i++) begin
         if (i == hold) redirect_ack = 1'b1;
         settle();
         chk("rd_valid", 32'(redirect_valid), 32'd1);
         chk("rd_pc", redirect_pc, target);
         chk("rd_busy", 32'(busy), 32'd1);
         chk("rd_ack", 32'(trap_ack), 32'd0);
         chk("rd_strobe", 32'(csr_bus.mstatus_rup), 32'd0);
         nxt();
      end
      redirect_ack = 1'b0;
      settle();
      chk("post_rv", 32'(redirect_valid), 32'd0);
      chk("post_rpc", redirect_pc, RESET_PC);
   endtask

   initial begin
      RST = 1'b1; ex_valid = 0; ex_cause = 0; ex_epc = 0; ex_badaddr = 0;
      mret_valid = 0; int_pc = 0; mtvec = 0; redirect_ack = 0;
      csr_bus.mepc = 0; csr_bus.mstatus = 0; csr_bus.mip = 0; csr_bus.mie = 0;
      nxt(); nxt();
      RST = 1'b0;
      csr_bus.mip = 32'h0000_0080;
      for (int i = 0; i < 10; i++) begin
         settle();
         idle_chk("reset");
         nxt();
      end

      // Exception: cause 2, epc 0x100, mtvec 0x1C1 -> redirect 0x1C0.
      do_req(1, 4'd2, 32'h100, 32'h0, 0, 32'h0, 32'h0, 32'h0, 32'h8, 32'h1C1, 2);
      nxt();
      // MRET to 0x104 with mpie set.
      csr_bus.mepc = 32'h104;
      do_req(0, 4'd0, 32'h0, 32'h0, 1, 32'h0, 32'h0, 32'h0, 32'h0000_0080, 32'h1C1, 1);
      nxt();
      // All three interrupts pending: MEI wins.
      do_req(0, 4'd0, 32'h0, 32'h0, 0, 32'h40, 32'h888, 32'h888, 32'h8, 32'h400, 0);
      nxt();
      // Exception and MRET together, redirect held 5 cycles; MRET next.
      do_req(1, 4'd7, 32'h500, 32'h1234, 1, 32'h0, 32'h0, 32'h0, 32'h8, 32'h800, 5);
      do_req(0, 4'd0, 32'h0, 32'h0, 1, 32'h0, 32'h0, 32'h0, csr_bus.mstatus, 32'h800, 0);
      nxt();

      // Reset while in STATUS aborts the mstatus write and the redirect.
      ex_valid = 1; ex_cause = 4'd5; ex_epc = 32'h300; ex_badaddr = 32'h44;
      csr_bus.mstatus = 32'h8; csr_bus.mip = 0;
      settle();
      chk("rst_c0_ack", 32'(trap_ack), 32'd1);
      nxt();
      ex_valid = 0;
      settle();
      chk("rst_save", 32'(csr_bus.mepc_rup), 32'd1);
      nxt();
      RST = 1'b1;
      settle();
      chk("rst_no_mst", 32'(csr_bus.mstatus_rup), 32'd0);
      chk("rst_no_rv", 32'(redirect_valid), 32'd0);
      nxt();
      RST = 1'b0;
      for (int i = 0; i < 4; i++) begin
         settle();
         idle_chk("after_rst");
         nxt();
      end

      for (int n = 0; n < 40; n++) begin
         csr_bus.mepc = $urandom & 32'hFFFF_FFFC;
         do_req($urandom_range(0, 3) == 0, 4'($urandom_range(0, 11)), $urandom, $urandom,
                $urandom_range(0, 2) == 0, $urandom, $urandom & 32'h888, $urandom & 32'h888,
                $urandom, $urandom, $urandom_range(0, 3));
         ex_valid = 0; mret_valid = 0; csr_bus.mip = 0;
         nxt();
      end
      settle();
      idle_chk("final");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
